// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
// Optional tick counter in the top level is enabled by CLKDIV_TICKCNT_EN.
package clkdiv_pkg;

    localparam int CLKDIV_CNT_W     = 26;
    localparam int CLKDIV_DIV_RESET = 2 ** 25;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } clkdiv_state_t;

    typedef logic [CLKDIV_CNT_W-1:0] clkdiv_cnt_t;

endpackage

// File: rtl/clkdiv_reload.sv
// Pending half-period register and RUN/PEND handshake; the new value is
// only released to the counter on a wrap so a half-period never truncates.
module clkdiv_reload
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = CLKDIV_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    input  logic             wrap,
    output logic [CNT_W-1:0] pend_val,
    output logic             busy,
    output logic             apply
);

    clkdiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    // NOTE: every variable assigned here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        // A wrap releases the value captured earlier; a load in the same
        // cycle becomes the next pending value and keeps us in PEND.
        if (state_q == PEND && wrap) begin
            state_d = RUN;
        end
        if (div_load) begin
            pend_d  = (div_val == '0) ? CNT_W'(1) : div_val;
            state_d = PEND;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        // NOTE: the pending register is reset too, so a discarded load can
        // never reappear after reset.
        if (!rstn) begin
            state_q <= RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign pend_val = pend_q;
    assign busy     = (state_q == PEND);
    assign apply    = (state_q == PEND) && wrap;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable 50% duty clock divider with aligned tick strobe.
// Define CLKDIV_TICKCNT_EN to add the 16-bit tick_cnt output.
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W     = CLKDIV_CNT_W,
    parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(CLKDIV_DIV_RESET)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_busy,
    output logic [CNT_W-1:0] cur_div,
`ifdef CLKDIV_TICKCNT_EN
    output logic [15:0]      tick_cnt,
`endif
    output logic             out_clk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             out_clk_q, out_clk_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] pend_val;

    clkdiv_reload #(
        .CNT_W (CNT_W)
    ) u_reload (
        .clk      (clk),
        .rstn     (rstn),
        .div_load (div_load),
        .div_val  (div_val),
        .wrap     (wrap),
        .pend_val (pend_val),
        .busy     (div_busy),
        .apply    (apply)
    );

    assign wrap = en && (cnt_q == cur_div_q - CNT_W'(1));

    always_comb begin
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        out_clk_d = out_clk_q;
        tick_d    = 1'b0;
        if (wrap) begin
            cnt_d     = '0;
            out_clk_d = ~out_clk_q;
            tick_d    = ~out_clk_q;
            // New N only takes over at a half-period boundary.
            if (apply) begin
                cur_div_d = pend_val;
            end
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            cur_div_q <= DIV_RESET;
            out_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign cur_div = cur_div_q;
    assign out_clk = out_clk_q;
    assign tick    = tick_q;

`ifdef CLKDIV_TICKCNT_EN
    logic [15:0] tick_cnt_q, tick_cnt_d;

    // Counted from tick_d so the count moves in the same cycle tick is high.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (tick_d) begin
            tick_cnt_d = tick_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog with CNT_W=8, DIV_RESET=3.
module tb_clock_divider_prog;

    localparam int         CNT_W   = 8;
    localparam logic [7:0] DIV_RST = 8'd3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_busy;
    logic [CNT_W-1:0] cur_div;
    logic             out_clk;
    logic             tick;
`ifdef CLKDIV_TICKCNT_EN
    logic [15:0]      tick_cnt;
`endif

    clock_divider_prog #(
        .CNT_W     (CNT_W),
        .DIV_RESET (DIV_RST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .div_load (div_load),
        .div_val  (div_val),
        .div_busy (div_busy),
        .cur_div  (cur_div),
`ifdef CLKDIV_TICKCNT_EN
        .tick_cnt (tick_cnt),
`endif
        .out_clk  (out_clk),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       out;
        logic       tck;
        logic       busy;
        logic [7:0] cur;
        logic [15:0] tcnt;
    } exp_t;

    typedef struct {
        logic       rstn;
        logic       en;
        logic       load;
        logic [7:0] val;
        exp_t       exp;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counts remaining cycles down rather than up.
    logic        m_out, m_tick, m_pv;
    logic [7:0]  m_cur, m_pend;
    logic [15:0] m_tcnt;
    int          m_rem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic [7:0] v);
        @(negedge clk);
        rstn     = r;
        en       = e;
        div_load = l;
        div_val  = v;
    endtask

    task automatic model_step();
        if (!rstn) begin
            m_out = 1'b0; m_tick = 1'b0; m_rem = int'(DIV_RST); m_cur = DIV_RST;
            m_pv = 1'b0; m_pend = '0; m_tcnt = '0;
        end else begin
            m_tick = 1'b0;
            if (en) begin
                if (m_rem == 1) begin
                    m_out  = !m_out;
                    m_tick = m_out;
                    if (m_pv) begin
                        m_cur = m_pend;
                        m_pv  = 1'b0;
                    end
                    m_rem = int'(m_cur);
                end else begin
                    m_rem--;
                end
            end
            if (div_load) begin
                m_pend = (div_val == 8'd0) ? 8'd1 : div_val;
                m_pv   = 1'b1;
            end
            if (m_tick) m_tcnt++;
        end
    endtask

    function automatic exp_t model_exp();
        return '{out: m_out, tck: m_tick, busy: m_pv, cur: m_cur, tcnt: m_tcnt};
    endfunction

    task automatic sample();
        exp_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("out_clk", 32'(out_clk), 32'(e.out));
        check("tick", 32'(tick), 32'(e.tck));
        check("div_busy", 32'(div_busy), 32'(e.busy));
        check("cur_div", 32'(cur_div), 32'(e.cur));
`ifdef CLKDIV_TICKCNT_EN
        check("tick_cnt", 32'(tick_cnt), 32'(e.tcnt));
`endif
    endtask

    task automatic run(input logic r, input logic e, input logic l, input logic [7:0] v);
        drive(r, e, l, v);
        model_step();
        exp_q.push_back(model_exp());
        sample();
    endtask

    function automatic vec_t mk(input logic r, input logic o, input logic t, input logic [15:0] tc);
        return '{rstn: r, en: 1'b1, load: 1'b0, val: 8'd0,
                 exp: '{out: o, tck: t, busy: 1'b0, cur: DIV_RST, tcnt: tc}};
    endfunction

    initial begin
        vec_t        vecs[14];
        logic [0:11] out_pat  = 12'b001110001110;
        logic [0:11] tick_pat = 12'b001000001000;
        logic [15:0] tc;

        // Reset then free-running at N=3, expectations written out by hand.
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1] = mk(1'b0, 1'b0, 1'b0, 16'd0);
        tc = '0;
        for (int k = 0; k < 12; k++) begin
            if (tick_pat[k]) tc++;
            vecs[2+k] = mk(1'b1, out_pat[k], tick_pat[k], tc);
        end
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rstn, vecs[i].en, vecs[i].load, vecs[i].val);
            model_step();
            exp_q.push_back(vecs[i].exp);
            sample();
        end

        // Load N=1 mid half-period: old half completes, then clk/2.
        run(1'b1, 1'b1, 1'b0, 8'd0);
        run(1'b1, 1'b1, 1'b1, 8'd1);
        check("busy_after_load", 32'(div_busy), 32'd1);
        check("cur_still_old", 32'(cur_div), 32'd3);
        for (int i = 0; i < 8; i++) run(1'b1, 1'b1, 1'b0, 8'd0);
        check("cur_is_1", 32'(cur_div), 32'd1);

        // Same-cycle load and wrap at N=1: 8 goes to pending only.
        run(1'b1, 1'b1, 1'b1, 8'd8);
        check("same_cycle_cur", 32'(cur_div), 32'd1);
        check("same_cycle_busy", 32'(div_busy), 32'd1);
        for (int i = 0; i < 4; i++) run(1'b1, 1'b1, 1'b0, 8'd0);

        // Two loads before one wrap: last value wins.
        run(1'b1, 1'b1, 1'b1, 8'd5);
        run(1'b1, 1'b1, 1'b0, 8'd0);
        run(1'b1, 1'b1, 1'b1, 8'd7);
        for (int i = 0; i < 36; i++) run(1'b1, 1'b1, 1'b0, 8'd0);
        check("last_load_wins", 32'(cur_div), 32'd7);

        // Zero load becomes N=1 with no lock-up.
        run(1'b1, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 12; i++) run(1'b1, 1'b1, 1'b0, 8'd0);
        check("zero_as_one", 32'(cur_div), 32'd1);

        // Freeze mid half-period at N=4, then resume.
        run(1'b1, 1'b1, 1'b1, 8'd4);
        for (int i = 0; i < 10; i++) run(1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) run(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 12; i++) run(1'b1, 1'b1, 1'b0, 8'd0);

        // Reset while pending with out_clk high.
        for (int i = 0; i < 20; i++) begin
            if (m_out) break;
            run(1'b1, 1'b1, 1'b0, 8'd0);
        end
        check("out_high_before_rst", 32'(out_clk), 32'd1);
        run(1'b1, 1'b1, 1'b1, 8'd6);
        check("pend_before_rst", 32'(div_busy), 32'd1);
        run(1'b0, 1'b1, 1'b1, 8'd9);
        check("rst_out", 32'(out_clk), 32'd0);
        check("rst_busy", 32'(div_busy), 32'd0);
        check("rst_cur", 32'(cur_div), 32'(DIV_RST));
        for (int i = 0; i < 40; i++) begin
            if (m_tcnt == 16'd4) break;
            run(1'b1, 1'b1, 1'b0, 8'd0);
        end
`ifdef CLKDIV_TICKCNT_EN
        check("tick_cnt_4", 32'(tick_cnt), 32'd4);
`endif
        for (int i = 0; i < 6; i++) run(1'b1, 1'b1, 1'b0, 8'd0);
        check("cur_reset_kept", 32'(cur_div), 32'(DIV_RST));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
